// File: rtl/enc_pkg.sv
// Shared encoding constants for the RV32I program loader and the decoder bench:
// mnemonic codes, opcode/funct fields, loader FSM states and word-builder helpers.
package enc_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9;
  localparam logic [4:0] OP_ANDI = 5'd10;
  localparam logic [4:0] OP_ORI  = 5'd11;
  localparam logic [4:0] OP_LW   = 5'd12;
  localparam logic [4:0] OP_SW   = 5'd13;
  localparam logic [4:0] OP_BEQ  = 5'd14;
  localparam logic [4:0] OP_JAL  = 5'd15;
  localparam logic [4:0] OP_JALR = 5'd16;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic signed [20:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic signed [20:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic signed [20:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic signed [20:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  // True when imm survives truncation to w bits and sign-extension back.
  function automatic logic fits_signed(input logic signed [20:0] imm, input int unsigned w);
    for (int unsigned i = w; i < 21; i++) begin
      if (imm[i] != imm[w-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/rv32_word_enc.sv
// Combinational mnemonic-to-RV32I encoder. Immediate range checking is compiled
// in only when ENC_RANGE_CHECK_EN is defined; otherwise immediates truncate.
module rv32_word_enc
  import enc_pkg::*;
(
  input  logic [4:0]         op_i,
  input  logic [4:0]         rd_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic signed [20:0] imm_i,
  output logic [31:0]        word_o,
  output logic               illegal_o,
  output logic               range_err_o
);

  logic i_bad, b_bad, j_bad;

`ifdef ENC_RANGE_CHECK_EN
  assign i_bad = !fits_signed(imm_i, 12);
  assign b_bad = !fits_signed(imm_i, 13) || imm_i[0];
  assign j_bad = imm_i[0];
`else
  assign i_bad = 1'b0;
  assign b_bad = 1'b0;
  assign j_bad = 1'b0;
`endif

  always_comb begin
    word_o      = '0;
    illegal_o   = 1'b0;
    range_err_o = 1'b0;
    case (op_i)
      OP_ADD:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP);
      OP_SUB:  word_o = enc_r(F7_ALT,  rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP);
      OP_AND:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_AND, rd_i, OPC_OP);
      OP_OR:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_OR,  rd_i, OPC_OP);
      OP_XOR:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_XOR, rd_i, OPC_OP);
      OP_SLT:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLT, rd_i, OPC_OP);
      OP_SLL:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLL, rd_i, OPC_OP);
      OP_SRL:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SR,  rd_i, OPC_OP);
      OP_SRA:  word_o = enc_r(F7_ALT,  rs2_i, rs1_i, F3_SR,  rd_i, OPC_OP);
      OP_ADDI: begin
        word_o      = enc_i(imm_i, rs1_i, F3_ADD, rd_i, OPC_OPIMM);
        range_err_o = i_bad;
      end
      OP_ANDI: begin
        word_o      = enc_i(imm_i, rs1_i, F3_AND, rd_i, OPC_OPIMM);
        range_err_o = i_bad;
      end
      OP_ORI: begin
        word_o      = enc_i(imm_i, rs1_i, F3_OR, rd_i, OPC_OPIMM);
        range_err_o = i_bad;
      end
      OP_LW: begin
        word_o      = enc_i(imm_i, rs1_i, F3_W, rd_i, OPC_LOAD);
        range_err_o = i_bad;
      end
      OP_JALR: begin
        word_o      = enc_i(imm_i, rs1_i, F3_ADD, rd_i, OPC_JALR);
        range_err_o = i_bad;
      end
      OP_SW: begin
        word_o      = enc_s(imm_i, rs2_i, rs1_i, F3_W, OPC_STORE);
        range_err_o = i_bad;
      end
      OP_BEQ: begin
        word_o      = enc_b(imm_i, rs2_i, rs1_i, F3_BEQ, OPC_BRANCH);
        range_err_o = b_bad;
      end
      OP_JAL: begin
        word_o      = enc_j(imm_i, rd_i, OPC_JAL);
        range_err_o = j_bad;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// On-chip program loader: encodes handshaked mnemonic commands into RV32I words
// and writes them sequentially into imem. Optional feature macro: ENC_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [20:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  import enc_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_illegal, enc_range_err;
  logic        hs, full;

  rv32_word_enc u_enc (
    .op_i        (cmd_op),
    .rd_i        (cmd_rd),
    .rs1_i       (cmd_rs1),
    .rs2_i       (cmd_rs2),
    .imm_i       (cmd_imm),
    .word_o      (enc_word),
    .illegal_o   (enc_illegal),
    .range_err_o (enc_range_err)
  );

  // A start in the same cycle wins, so never advertise ready then.
  assign cmd_ready = (state_q == ST_ACCEPT) && !start;
  assign hs        = cmd_valid && cmd_ready;
  assign full      = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    done_d  = done_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_ACCEPT;
      ptr_d   = ADDR_W'(BASE_ADDR);
      cnt_d   = '0;
      last_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (hs) begin
            if (enc_illegal || enc_range_err || full) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else begin
              word_d  = enc_word;
              last_d  = cmd_last;
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (last_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= ADDR_W'(BASE_ADDR);
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Encoded word is pure data; the output gating below keeps it invisible after reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = imem_we ? ptr_q  : '0;
  assign imem_wdata = imem_we ? word_q : '0;
  assign busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected imem writes are queued when
// a command is driven and matched against every observed write strobe.
module tb_instr_encoder_loader;
  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [4:0]        cmd_op = '0, cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [20:0]       cmd_imm = '0;
  logic              cmd_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   word_count;

  int total = 0;
  int bad   = 0;
  logic [39:0]       sb[$];
  logic [ADDR_W-1:0] exp_ptr;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("we_expected", 32'(imem_we), 32'(sb.size() > 0 && imem_we));
      if (imem_we && sb.size() > 0) begin
        logic [39:0] e;
        e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e[39:32]));
        chk("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic chk_zero(input string t);
    chk({t, "_ready"}, 32'(cmd_ready), 32'd0);
    chk({t, "_we"},    32'(imem_we),   32'd0);
    chk({t, "_addr"},  32'(imem_addr), 32'd0);
    chk({t, "_wdata"}, imem_wdata,     32'd0);
    chk({t, "_busy"},  32'(busy),      32'd0);
    chk({t, "_done"},  32'(done),      32'd0);
    chk({t, "_err"},   32'(err),       32'd0);
    chk({t, "_wc"},    32'(word_count), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_ptr = ADDR_W'(BASE_ADDR);
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [20:0] imm, input logic last,
                      input logic wr, input logic [31:0] w);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_last = last; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("hs_ready", 32'(cmd_ready), 32'd1);
    if (wr) begin
      sb.push_back({exp_ptr, w});
      exp_ptr = exp_ptr + ADDR_W'(1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic wait_flag(input string tag, input bit want_done);
    int n = 0;
    while (!(want_done ? done : err) && n < 20) begin @(negedge clk); n++; end
    chk(tag, 32'(want_done ? done : err), 32'd1);
  endtask

  initial begin
    exp_ptr = ADDR_W'(BASE_ADDR);
    #12 chk_zero("rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk_zero("idle");

    do_start();
    send(5'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h002081B3);
    send(5'd1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h402081B3);
    wait_flag("s1_done", 1'b1);
    chk("s1_wc", 32'(word_count), 32'd2);
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_err", 32'(err), 32'd0);

    do_start();
    send(5'd9,  5'd1, 5'd0, 5'd0, 21'd5, 1'b0, 1'b1, 32'h00500093);
    send(5'd12, 5'd5, 5'd1, 5'd0, 21'd4, 1'b0, 1'b1, 32'h0040A283);
    send(5'd13, 5'd0, 5'd1, 5'd2, 21'd8, 1'b1, 1'b1, 32'h0020A423);
    wait_flag("s2_done", 1'b1);
    chk("s2_wc", 32'(word_count), 32'd3);

    do_start();
    send(5'd14, 5'd0, 5'd1, 5'd2, 21'd8,  1'b0, 1'b1, 32'h00208463);
    send(5'd15, 5'd1, 5'd0, 5'd0, 21'd16, 1'b1, 1'b1, 32'h010000EF);
    wait_flag("s3_done", 1'b1);
    chk("s3_wc", 32'(word_count), 32'd2);

    do_start();
    send(5'd20, 5'd1, 5'd1, 5'd1, 21'd0, 1'b1, 1'b0, 32'h0);
    wait_flag("ill_err", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ill_ready", 32'(cmd_ready), 32'd0);
    end
    chk("ill_wc", 32'(word_count), 32'd0);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_done", 32'(done), 32'd0);

    do_start();
    chk("restart_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++)
      send(5'd0, 5'(i + 4), 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h00208033 | (32'(i + 4) << 7));
    send(5'd0, 5'd9, 5'd1, 5'd2, 21'd0, 1'b0, 1'b0, 32'h0);
    wait_flag("ovf_err", 1'b0);
    chk("ovf_wc", 32'(word_count), 32'd4);
    chk("ovf_done", 32'(done), 32'd0);

    do_start();
`ifdef ENC_RANGE_CHECK_EN
    send(5'd9, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1, 1'b0, 32'h0);
    wait_flag("rng_err", 1'b0);
    chk("rng_wc", 32'(word_count), 32'd0);
`else
    send(5'd9, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1, 1'b1, 32'h80000093);
    wait_flag("rng_done", 1'b1);
    chk("rng_wc", 32'(word_count), 32'd1);
`endif

    do_start();
    send(5'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge clk); rst_n = 1'b1;

    do_start();
    send(5'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h002081B3);
    do_start();
    send(5'd3, 5'd4, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h0020E233);
    wait_flag("mid_done", 1'b1);
    chk("mid_wc", 32'(word_count), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
